// File: rtl/lif_post_neuron_if.sv
// lif_post_neuron_if
//   Bundles the neuron's data-path signals: four presynaptic spike lines with
//   their packed 4-bit weights in, and the fire pulse plus observation outputs.
//   master : the driver of spikes/weights (the STDP block or a testbench)
//   slave  : the neuron itself
//   pre_spike[3:0]   presynaptic spikes, one bit per input neuron
//   weight[15:0]     packed weights, [15:12] belongs to pre_spike[0]
//   post_spike       one-cycle fire pulse
//   membrane[7:0]    current membrane potential
//   in_refractory    high while the neuron ignores input
//   spike_count[7:0] wrapping fire counter
interface lif_post_neuron_if;
  logic [3:0]  pre_spike;
  logic [15:0] weight;
  logic        post_spike;
  logic [7:0]  membrane;
  logic        in_refractory;
  logic [7:0]  spike_count;

  modport master (
    output pre_spike,
    output weight,
    input  post_spike,
    input  membrane,
    input  in_refractory,
    input  spike_count
  );

  modport slave (
    input  pre_spike,
    input  weight,
    output post_spike,
    output membrane,
    output in_refractory,
    output spike_count
  );
endinterface

// File: rtl/lif_post_neuron.sv
// lif_post_neuron
//   Leaky integrate-and-fire postsynaptic neuron. Each cycle the membrane
//   leaks by v >> LEAK_SHIFT, gains the weighted sum of active presynaptic
//   spikes (saturating at 255) and fires when the result reaches THRESHOLD.
//   A fire clears the membrane, pulses post_spike for one cycle and starts an
//   absolute refractory period of REFRAC_CYCLES cycles.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : lif_post_neuron_if.slave (spikes/weights in, pulse/state out)
module lif_post_neuron #(
  parameter logic [7:0] THRESHOLD     = 8'd32,
  parameter int         LEAK_SHIFT    = 3,
  parameter logic [3:0] REFRAC_CYCLES = 4'd4
) (
  input  logic              clk,
  input  logic              rst,
  lif_post_neuron_if.slave  bus
);

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] membrane_q, membrane_d;
  logic       post_q, post_d;
  logic [7:0] count_q, count_d;
  logic [3:0] refrac_q, refrac_d;

  // Per-synapse gated weight; pre_spike[i] pairs with the nibble counted
  // from the top of the weight bus.
  logic [5:0] syn_term [4];
  logic [5:0] syn_sum;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_syn
      assign syn_term[gi] = bus.pre_spike[gi] ? {2'b00, bus.weight[15-4*gi -: 4]} : 6'd0;
    end
  endgenerate

  assign syn_sum = syn_term[0] + syn_term[1] + syn_term[2] + syn_term[3];

  logic [7:0] v_leak;
  logic [8:0] v_sum;
  logic [7:0] v_sat;
  logic       accept;

  assign v_leak = membrane_q - (membrane_q >> LEAK_SHIFT);
  assign v_sum  = {1'b0, v_leak} + {3'b000, syn_sum};
  assign v_sat  = v_sum[8] ? 8'hFF : v_sum[7:0];

  // The last refractory cycle already integrates, so input is taken at the
  // edge that ends the refractory period (membrane is 0 there, so v_sat = I).
  assign accept = (state_q == ST_INTEGRATE) || (refrac_q == 4'd1);

  always_comb begin
    state_d    = state_q;
    membrane_d = membrane_q;
    post_d     = 1'b0;
    count_d    = count_q;
    refrac_d   = refrac_q;

    if (state_q == ST_REFRACTORY) begin
      membrane_d = 8'd0;
      refrac_d   = refrac_q - 4'd1;
      if (refrac_q == 4'd1) begin
        state_d = ST_INTEGRATE;
      end
    end

    if (accept) begin
      if (v_sat >= THRESHOLD) begin
        membrane_d = 8'd0;
        post_d     = 1'b1;
        count_d    = count_q + 8'd1;
        refrac_d   = REFRAC_CYCLES;
        state_d    = (REFRAC_CYCLES != 4'd0) ? ST_REFRACTORY : ST_INTEGRATE;
      end else begin
        membrane_d = v_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INTEGRATE;
      membrane_q <= 8'd0;
      post_q     <= 1'b0;
      count_q    <= 8'd0;
      refrac_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      membrane_q <= membrane_d;
      post_q     <= post_d;
      count_q    <= count_d;
      refrac_q   <= refrac_d;
    end
  end

  assign bus.post_spike    = post_q;
  assign bus.membrane      = membrane_q;
  assign bus.in_refractory = (state_q == ST_REFRACTORY);
  assign bus.spike_count   = count_q;

endmodule

// File: tb/tb_lif_post_neuron.sv
// tb_lif_post_neuron
//   Drives three neuron instances with shared spikes/weights/reset:
//     A : THRESHOLD 32,  REFRAC 4   (default behaviour)
//     B : THRESHOLD 255, REFRAC 4   (saturation)
//     C : THRESHOLD 32,  REFRAC 0   (back-to-back fires, counter wrap)
//   Every step compares all outputs against a behavioural model; directed
//   steps additionally check hand-computed constants.
module tb_lif_post_neuron;

  logic clk;
  logic rst;

  lif_post_neuron_if ifa ();
  lif_post_neuron_if ifb ();
  lif_post_neuron_if ifc ();

  lif_post_neuron #(.THRESHOLD(8'd32),  .LEAK_SHIFT(3), .REFRAC_CYCLES(4'd4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  lif_post_neuron #(.THRESHOLD(8'd255), .LEAK_SHIFT(3), .REFRAC_CYCLES(4'd4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));
  lif_post_neuron #(.THRESHOLD(8'd32),  .LEAK_SHIFT(3), .REFRAC_CYCLES(4'd0)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs gathered per instance
  logic [7:0] o_mem [3];
  logic       o_post[3];
  logic       o_ref [3];
  logic [7:0] o_cnt [3];
  assign o_mem[0] = ifa.membrane;  assign o_post[0] = ifa.post_spike;
  assign o_ref[0] = ifa.in_refractory; assign o_cnt[0] = ifa.spike_count;
  assign o_mem[1] = ifb.membrane;  assign o_post[1] = ifb.post_spike;
  assign o_ref[1] = ifb.in_refractory; assign o_cnt[1] = ifb.spike_count;
  assign o_mem[2] = ifc.membrane;  assign o_post[2] = ifc.post_spike;
  assign o_ref[2] = ifc.in_refractory; assign o_cnt[2] = ifc.spike_count;

  // Behavioural model: refr_left counts refractory cycles still to be shown,
  // including the current one; input is integrated whenever refr_left <= 1.
  int m_thr [3] = '{32, 255, 32};
  int m_rf  [3] = '{4, 4, 0};
  int m_v   [3];
  int m_post[3];
  int m_refl[3];
  int m_cnt [3];

  int tests_run = 0;
  int failed    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_update(input logic r, input logic [3:0] p, input logic [15:0] w);
    int syn;
    int tot;
    syn = 0;
    for (int i = 0; i < 4; i++)
      if (p[i]) syn += (w >> (12 - 4*i)) & 15;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_v[k] = 0; m_post[k] = 0; m_refl[k] = 0; m_cnt[k] = 0;
      end else if (m_refl[k] > 1) begin
        m_refl[k]--; m_v[k] = 0; m_post[k] = 0;
      end else begin
        tot = m_v[k] - m_v[k] / 8 + syn;
        if (tot > 255) tot = 255;
        if (tot >= m_thr[k]) begin
          m_v[k] = 0; m_post[k] = 1; m_cnt[k] = (m_cnt[k] + 1) % 256;
          m_refl[k] = m_rf[k];
        end else begin
          m_v[k] = tot; m_post[k] = 0; m_refl[k] = 0;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] p, input logic [15:0] w);
    rst = r;
    ifa.pre_spike = p; ifa.weight = w;
    ifb.pre_spike = p; ifb.weight = w;
    ifc.pre_spike = p; ifc.weight = w;
    @(posedge clk);
    model_update(r, p, w);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_mem[%0d]", k),  32'(o_mem[k]),  32'(m_v[k]));
      chk($sformatf("model_post[%0d]", k), 32'(o_post[k]), 32'(m_post[k]));
      chk($sformatf("model_ref[%0d]", k),  32'(o_ref[k]),  32'(m_refl[k] > 0));
      chk($sformatf("model_cnt[%0d]", k),  32'(o_cnt[k]),  32'(m_cnt[k]));
    end
  endtask

  int leak_exp [6] = '{10, 19, 27, 24, 21, 19};

  initial begin
    rst = 1'b1;
    ifa.pre_spike = '0; ifa.weight = '0;
    ifb.pre_spike = '0; ifb.weight = '0;
    ifc.pre_spike = '0; ifc.weight = '0;
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_post[k] = 0; m_refl[k] = 0; m_cnt[k] = 0;
    end

    // Reset overrides maximal input
    step(1'b1, 4'hF, 16'hFFFF);
    step(1'b1, 4'hF, 16'hFFFF);
    chk("rst_mem", 32'(ifa.membrane), 0);
    chk("rst_post", 32'(ifa.post_spike), 0);
    chk("rst_ref", 32'(ifa.in_refractory), 0);
    chk("rst_cnt", 32'(ifa.spike_count), 0);

    // Exact threshold: I = 32 fires
    step(1'b0, 4'hF, 16'h8888);
    chk("thr_eq_post", 32'(ifa.post_spike), 1);
    chk("thr_eq_mem", 32'(ifa.membrane), 0);
    chk("thr_eq_cnt", 32'(ifa.spike_count), 1);
    chk("thr_eq_ref", 32'(ifa.in_refractory), 1);

    // One below threshold: I = 31 stays
    step(1'b1, 4'h0, 16'h0000);
    step(1'b0, 4'hF, 16'h7888);
    chk("thr_lo_mem", 32'(ifa.membrane), 31);
    chk("thr_lo_post", 32'(ifa.post_spike), 0);

    // Leak and truncation, sub-threshold
    step(1'b1, 4'h0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 3) ? 4'b0001 : 4'b0000, 16'hA000);
      chk($sformatf("leak_mem[%0d]", i), 32'(ifa.membrane), 32'(leak_exp[i]));
      chk($sformatf("leak_post[%0d]", i), 32'(ifa.post_spike), 0);
    end

    // Refractory period with maximal input held
    step(1'b1, 4'h0, 16'h0000);
    for (int c = 1; c <= 5; c++) begin
      step(1'b0, 4'hF, 16'hFFFF);
      chk($sformatf("refr_post[%0d]", c), 32'(ifa.post_spike), 32'(c == 1 || c == 5));
      chk($sformatf("refr_ref[%0d]", c), 32'(ifa.in_refractory), 32'(c <= 4 || c == 5));
      chk($sformatf("refr_mem[%0d]", c), 32'(ifa.membrane), 0);
    end
    chk("refr_cnt", 32'(ifa.spike_count), 2);

    // Reset in the middle of refractory
    step(1'b1, 4'h0, 16'h0000);
    step(1'b0, 4'hF, 16'hFFFF);
    step(1'b0, 4'hF, 16'hFFFF);
    chk("mid_ref_before", 32'(ifa.in_refractory), 1);
    step(1'b1, 4'hF, 16'hFFFF);
    chk("mid_ref_after", 32'(ifa.in_refractory), 0);
    chk("mid_ref_cnt", 32'(ifa.spike_count), 0);

    // Saturation on the THRESHOLD=255 instance: 60,113,159,200,235,250 then +60
    for (int i = 0; i < 5; i++) step(1'b0, 4'hF, 16'hFFFF);
    chk("sat_pre235", 32'(ifb.membrane), 235);
    step(1'b0, 4'hF, 16'hBBBB);
    chk("sat_pre250", 32'(ifb.membrane), 250);
    step(1'b0, 4'hF, 16'hFFFF);
    chk("sat_post", 32'(ifb.post_spike), 1);
    chk("sat_mem", 32'(ifb.membrane), 0);

    // Counter wrap on the REFRAC=0 instance: fires every cycle
    step(1'b1, 4'h0, 16'h0000);
    for (int i = 1; i <= 256; i++) begin
      step(1'b0, 4'hF, 16'hFFFF);
      if (i == 255) chk("wrap_255", 32'(ifc.spike_count), 255);
    end
    chk("wrap_cnt", 32'(ifc.spike_count), 0);
    chk("wrap_post", 32'(ifc.post_spike), 1);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), 4'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/lif_post_neuron.md
# lif_post_neuron

Leaky integrate-and-fire postsynaptic neuron that closes the STDP loop. Consumes the four presynaptic spike lines and the packed 16-bit weight bus produced by the STDP learning block, integrates weighted input into a leaking membrane potential, and emits the single-cycle `post_spike` pulse that the STDP block consumes. Includes an absolute refractory period and a wrapping spike counter for observation.

## Interface
- `THRESHOLD`, 8'd32: firing threshold; fire when next potential ≥ THRESHOLD (1..255).
- `LEAK_SHIFT`, 3: per-cycle leak is `v >> LEAK_SHIFT` (1..7).
- `REFRAC_CYCLES`, 4: refractory length in cycles (0..15; 0 = none).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pre_spike`  in  4  presynaptic spikes, one bit per neuron, sampled every cycle.
- `weight`  in  16  packed weights: [15:12] for pre_spike[0], [11:8] for [1], [7:4] for [2], [3:0] for [3]; unsigned.
- `post_spike`  out  1  registered one-cycle fire pulse.
- `membrane`  out  8  current membrane potential, unsigned.
- `in_refractory`  out  1  high while in REFRACTORY state.
- `spike_count`  out  8  number of fires, wraps 255→0.

## Operation
- Two states: INTEGRATE, REFRACTORY. Reset state INTEGRATE.
- Synaptic input I = Σ (pre_spike[i] ? w_i : 0), 6-bit, range 0..60.
- INTEGRATE, each cycle: v_leak = v − (v >> LEAK_SHIFT); v_next = min(v_leak + I, 255), computed in ≥9 bits then saturated.
  - v_next ≥ THRESHOLD: membrane ← 0, post_spike ← 1, spike_count ← +1, refrac_cnt ← REFRAC_CYCLES; state ← REFRACTORY if REFRAC_CYCLES ≠ 0, else stay INTEGRATE.
  - otherwise: membrane ← v_next, post_spike ← 0.
- REFRACTORY, each cycle: post_spike ← 0, membrane held 0, pre_spike/weight ignored, refrac_cnt −1; when refrac_cnt == 1, state ← INTEGRATE.
- Leak truncates: small v may not decay to 0 (e.g. v=4, shift 3 stays 4); this is required behaviour.
- Weights are sampled combinationally in the cycle they are used; weight changes during a cycle with no spikes have no effect.

## Timing
- Reset (any state, including mid-refractory): membrane=0, post_spike=0, in_refractory=0, spike_count=0, refrac_cnt=0, state INTEGRATE; takes effect on the edge where rst=1, overriding all inputs.
- Latency: spike input at edge k → membrane/post_spike updated after edge k (visible in cycle k+1). One cycle input-to-fire.
- post_spike is exactly one cycle wide; never asserted in consecutive cycles when REFRAC_CYCLES ≥ 1.
- in_refractory rises in the same cycle post_spike is high, stays high REFRAC_CYCLES cycles total; input first accepted at the edge ending the last refractory cycle.
- REFRAC_CYCLES=0: back-to-back fires allowed every cycle.
- Threshold comparison uses saturated v_next; equality fires.

## Test plan
- Reset: drive rst=1 with pre_spike=4'hF, weight=16'hFFFF -> all outputs 0; after rst falls, first integration occurs on the next edge.
- Exact threshold: v=0, weight=16'h8888, pre_spike=4'hF one cycle -> post_spike=1 next cycle, membrane=0, spike_count=1; repeat from reset with 16'h7888 -> membrane=31, no spike.
- Leak/sub-threshold: weight=16'hA000, pre_spike=4'b0001 for 3 cycles then 0 -> membrane 10, 19, 27, 24, 21, 19; post_spike never asserted.
- Refractory: weight=16'hFFFF, pre_spike=4'hF held -> post_spike at cycle 1, in_refractory high cycles 1–4, membrane 0 throughout, next post_spike at cycle 5, spike_count=2.
- Saturation (THRESHOLD=255 instance): pre-load v=250 via inputs, then I=60 -> v_next saturates to 255, fires, membrane=0.
- Reset mid-refractory and counter wrap: assert rst during cycle 2 of refractory -> in_refractory=0, state INTEGRATE next cycle; with REFRAC_CYCLES=0 and constant max input, 256 fires -> spike_count returns to 0.
